// File: rtl/sobel_core.sv
// rtl/sobel_core.sv - three-stage Sobel |Gx|+|Gy| magnitude with edge threshold
// and output row/column tracking for the frame controller.
module sobel_core #(
  parameter int MAX_ROW   = 540,
  parameter int MAX_COL   = 540,
  parameter int THRESHOLD = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       core_en_i,
  input  logic       clear_i,
  input  logic [7:0] data_0_0_i,
  input  logic [7:0] data_0_1_i,
  input  logic [7:0] data_0_2_i,
  input  logic [7:0] data_1_0_i,
  input  logic [7:0] data_1_1_i,
  input  logic [7:0] data_1_2_i,
  input  logic [7:0] data_2_0_i,
  input  logic [7:0] data_2_1_i,
  input  logic [7:0] data_2_2_i,
  output logic [7:0] pix_o,
  output logic       edge_o,
  output logic       data_valid_o,
  output logic [9:0] out_col_o,
  output logic [9:0] out_row_o,
  output logic       row_done_o,
  output logic       frame_done_o
);

  localparam logic [9:0] LAST_COL = 10'(MAX_COL - 3);
  localparam logic [9:0] LAST_ROW = 10'(MAX_ROW - 3);
  localparam logic [8:0] THR      = 9'(THRESHOLD);

  function automatic logic [9:0] tap3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Signed 11-bit difference keeps the full -1020..1020 range before the abs.
  function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
    logic signed [10:0] d;
    logic signed [10:0] neg;
    d   = $signed({1'b0, p}) - $signed({1'b0, n});
    neg = -d;
    return d[10] ? neg[9:0] : d[9:0];
  endfunction

  logic [9:0]  gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [9:0]  gx_p_d, gx_n_d, gy_p_d, gy_n_d;
  logic [9:0]  ax_q, ay_q, ax_d, ay_d;
  logic [10:0] sum_d;
  logic [7:0]  pix_d;
  logic        v1_q, v2_q, valid_q, edge_q;
  logic [7:0]  pix_q;
  logic [9:0]  col_q, row_q, col_d, row_d;

  always_comb begin
    gx_p_d = tap3(data_0_2_i, data_1_2_i, data_2_2_i);
    gx_n_d = tap3(data_0_0_i, data_1_0_i, data_2_0_i);
    gy_p_d = tap3(data_2_0_i, data_2_1_i, data_2_2_i);
    gy_n_d = tap3(data_0_0_i, data_0_1_i, data_0_2_i);
    ax_d   = absdiff(gx_p_q, gx_n_q);
    ay_d   = absdiff(gy_p_q, gy_n_q);
    sum_d  = {1'b0, ax_q} + {1'b0, ay_q};
    pix_d  = (sum_d > 11'd255) ? 8'hFF : sum_d[7:0];
  end

  // Position of the next result, advanced only past a valid output.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_q) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_p_q  <= '0;
      gx_n_q  <= '0;
      gy_p_q  <= '0;
      gy_n_q  <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      edge_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else if (clear_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      edge_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      v1_q <= core_en_i;
      if (core_en_i) begin
        gx_p_q <= gx_p_d;
        gx_n_q <= gx_n_d;
        gy_p_q <= gy_p_d;
        gy_n_q <= gy_n_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        ax_q <= ax_d;
        ay_q <= ay_d;
      end
      valid_q <= v2_q;
      if (v2_q) begin
        pix_q  <= pix_d;
        edge_q <= ({1'b0, pix_d} >= THR);
      end
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign pix_o        = pix_q;
  assign edge_o       = edge_q;
  assign data_valid_o = valid_q;
  assign out_col_o    = col_q;
  assign out_row_o    = row_q;
  assign row_done_o   = valid_q && (col_q == LAST_COL);
  assign frame_done_o = row_done_o && (row_q == LAST_ROW);

endmodule

// File: tb/tb_sobel_core.sv
// tb/tb_sobel_core.sv - randomized and directed checks of sobel_core against a
// plain-arithmetic Sobel model with a 6x5 image.
module tb_sobel_core;

  localparam int MAX_COL = 6;
  localparam int MAX_ROW = 5;
  localparam int OCOLS   = MAX_COL - 2;
  localparam int OROWS   = MAX_ROW - 2;
  localparam int THR     = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       core_en_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] win [9];
  logic [7:0] pix_o;
  logic       edge_o, data_valid_o, row_done_o, frame_done_o;
  logic [9:0] out_col_o, out_row_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sobel_core #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .core_en_i(core_en_i), .clear_i(clear_i),
    .data_0_0_i(win[0]), .data_0_1_i(win[1]), .data_0_2_i(win[2]),
    .data_1_0_i(win[3]), .data_1_1_i(win[4]), .data_1_2_i(win[5]),
    .data_2_0_i(win[6]), .data_2_1_i(win[7]), .data_2_2_i(win[8]),
    .pix_o(pix_o), .edge_o(edge_o), .data_valid_o(data_valid_o),
    .out_col_o(out_col_o), .out_row_o(out_row_o),
    .row_done_o(row_done_o), .frame_done_o(frame_done_o)
  );

  function automatic int px(input int i);
    return int'(win[i]);
  endfunction

  function automatic int sobel_ref();
    int gx, gy, s;
    gx = (px(2) + 2 * px(5) + px(8)) - (px(0) + 2 * px(3) + px(6));
    gy = (px(6) + 2 * px(7) + px(8)) - (px(0) + 2 * px(1) + px(2));
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic rand_win();
    for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic step(input logic en, input logic clr);
    core_en_i = en;
    clear_i   = clr;
    @(posedge clk);
    #1;
    core_en_i = 1'b0;
    clear_i   = 1'b0;
  endtask

  task automatic test_reset();
    rand_win();
    core_en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({data_valid_o, pix_o, edge_o, out_col_o, out_row_o, row_done_o, frame_done_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b pix=%0d edge=%0b col=%0d row=%0d rd=%0b fd=%0b, required all 0",
               data_valid_o, pix_o, edge_o, out_col_o, out_row_o, row_done_o, frame_done_o);
    end
    core_en_i = 1'b0;
    rst = 1'b0;
  endtask

  // Directed windows: mode 0 sets columns (left,mid,right), mode 1 sets rows (top,mid,bottom).
  task automatic test_patterns();
    int mode [5] = '{0, 0, 0, 1, 1};
    int va   [5] = '{100, 0, 0, 200, 0};
    int vb   [5] = '{100, 5, 0, 0, 0};
    int vc   [5] = '{100, 10, 255, 0, 30};
    int vexp [5] = '{0, 40, 255, 255, 120};
    int exp_pix;
    for (int k = 0; k < 25; k++) begin
      if (k < 5) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            int sel;
            sel = (mode[k] == 0) ? c : r;
            win[r * 3 + c] = 8'(sel == 0 ? va[k] : (sel == 1 ? vb[k] : vc[k]));
          end
        exp_pix = vexp[k];
      end else begin
        rand_win();
        exp_pix = sobel_ref();
      end
      step(1'b0, 1'b1);
      n_checks++;
      if (pix_o !== 8'd0 || data_valid_o !== 1'b0 || out_col_o !== 10'd0) begin
        n_fail++;
        $display("FAIL clear_zero[%0d]: pix=%0d valid=%0b col=%0d, required 0 0 0", k, pix_o, data_valid_o, out_col_o);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_checks++;
      if (data_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid[%0d]: valid=%0b, required 0", k, data_valid_o);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (data_valid_o !== 1'b1 || pix_o !== 8'(exp_pix) || edge_o !== (exp_pix >= THR) ||
          out_col_o !== 10'd0 || out_row_o !== 10'd0 || row_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL pattern[%0d]: valid=%0b pix=%0d edge=%0b col=%0d row=%0d rd=%0b, required 1 %0d %0b 0 0 0",
                 k, data_valid_o, pix_o, edge_o, out_col_o, out_row_o, row_done_o, exp_pix, exp_pix >= THR);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (data_valid_o !== 1'b0 || pix_o !== 8'(exp_pix) || out_col_o !== 10'd1) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%0b pix=%0d col=%0d, required 0 %0d 1", k, data_valid_o, pix_o, out_col_o, exp_pix);
      end
    end
  endtask

  task automatic test_stream(input bit bubbles, input int nwin);
    int exp_q [$];
    bit en_h [128];
    int issued, out_n, cyc, e;
    step(1'b0, 1'b1);
    issued = 0;
    out_n  = 0;
    cyc    = 0;
    while (cyc < 100 && (issued < nwin || cyc < 2 || en_h[cyc - 1] || en_h[cyc - 2])) begin
      en_h[cyc] = (issued < nwin) && (!bubbles || (cyc % 2 == 0));
      if (en_h[cyc]) begin
        rand_win();
        exp_q.push_back(sobel_ref());
        issued++;
      end
      step(en_h[cyc], 1'b0);
      n_checks++;
      if (data_valid_o !== ((cyc >= 2) ? en_h[cyc - 2] : 1'b0)) begin
        n_fail++;
        $display("FAIL stream_valid[b=%0b c=%0d]: valid=%0b, required %0b", bubbles, cyc, data_valid_o,
                 (cyc >= 2) ? en_h[cyc - 2] : 1'b0);
      end
      if (data_valid_o === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (pix_o !== 8'(e) || edge_o !== (e >= THR) ||
            out_col_o !== 10'(out_n % OCOLS) || out_row_o !== 10'((out_n / OCOLS) % OROWS) ||
            row_done_o !== (out_n % OCOLS == OCOLS - 1) ||
            frame_done_o !== (out_n % (OCOLS * OROWS) == OCOLS * OROWS - 1)) begin
          n_fail++;
          $display("FAIL stream_out[b=%0b n=%0d]: pix=%0d edge=%0b col=%0d row=%0d rd=%0b fd=%0b, required pix=%0d col=%0d row=%0d rd=%0b fd=%0b",
                   bubbles, out_n, pix_o, edge_o, out_col_o, out_row_o, row_done_o, frame_done_o,
                   e, out_n % OCOLS, (out_n / OCOLS) % OROWS, out_n % OCOLS == OCOLS - 1,
                   out_n % (OCOLS * OROWS) == OCOLS * OROWS - 1);
        end
        out_n++;
      end else if (row_done_o !== 1'b0 || frame_done_o !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_done_idle[b=%0b c=%0d]: rd=%0b fd=%0b, required 0 0", bubbles, cyc, row_done_o, frame_done_o);
      end
      cyc++;
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (out_n != nwin || out_col_o !== 10'(nwin % OCOLS) || out_row_o !== 10'((nwin / OCOLS) % OROWS)) begin
      n_fail++;
      $display("FAIL stream_end[b=%0b]: outputs=%0d col=%0d row=%0d, required %0d %0d %0d", bubbles, out_n,
               out_col_o, out_row_o, nwin, nwin % OCOLS, (nwin / OCOLS) % OROWS);
    end
  endtask

  task automatic test_abort_inflight(input bit use_rst);
    int e;
    step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      rand_win();
      step(1'b1, 1'b0);
    end
    n_checks++;
    if (out_col_o !== 10'd2 || data_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort[rst=%0b]: col=%0d valid=%0b, required 2 1", use_rst, out_col_o, data_valid_o);
    end
    if (use_rst) begin
      rst = 1'b1;
      #2;
      n_checks++;
      if ({data_valid_o, pix_o, edge_o, out_col_o, out_row_o} !== '0) begin
        n_fail++;
        $display("FAIL async_reset: valid=%0b pix=%0d col=%0d row=%0d, required all 0", data_valid_o, pix_o, out_col_o, out_row_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      rand_win();
      step(1'b1, 1'b1);
      n_checks++;
      if (data_valid_o !== 1'b0 || pix_o !== 8'd0 || out_col_o !== 10'd0 || out_row_o !== 10'd0) begin
        n_fail++;
        $display("FAIL clear_abort: valid=%0b pix=%0d col=%0d row=%0d, required 0 0 0 0", data_valid_o, pix_o, out_col_o, out_row_o);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (data_valid_o !== 1'b0 || out_col_o !== 10'd0) begin
        n_fail++;
        $display("FAIL dropped[rst=%0b %0d]: valid=%0b col=%0d, required 0 0", use_rst, k, data_valid_o, out_col_o);
      end
    end
    rand_win();
    e = sobel_ref();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++;
    if (data_valid_o !== 1'b1 || pix_o !== 8'(e) || out_col_o !== 10'd0 || out_row_o !== 10'd0) begin
      n_fail++;
      $display("FAIL post_abort[rst=%0b]: valid=%0b pix=%0d col=%0d row=%0d, required 1 %0d 0 0",
               use_rst, data_valid_o, pix_o, out_col_o, out_row_o, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) win[i] = 8'd0;
    test_reset();
    test_patterns();
    test_stream(1'b0, 14);
    test_stream(1'b1, 12);
    test_abort_inflight(1'b1);
    test_abort_inflight(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_core.md
Name: sobel_core

Overview:
- Downstream consumer of the 3x3 window preprocessor. Each enabled cycle it takes nine 8-bit pixels and computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits, plus a thresholded edge bit.
- Fully pipelined, 3-cycle latency, one result per enabled cycle.
- Tracks output column/row position and reports row-done and frame-done to the controller.

Parameters:
- MAX_ROW, 540, input image rows; output rows = MAX_ROW-2.
- MAX_COL, 540, input image columns; output columns per row = MAX_COL-2.
- THRESHOLD, 128, 8-bit edge threshold; edge_o = (pix_o >= THRESHOLD).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_en_i  in  1  window valid; when high, the nine data_r_c_i inputs are sampled this edge.
- clear_i  in  1  synchronous abort/new-frame; clears pipeline valids and position counters.
- data_0_0_i..data_2_2_i  in  8 each  window pixels, row r (0 = top), column c (0 = left), unsigned.
- pix_o  out  8  saturated gradient magnitude.
- edge_o  out  1  pix_o >= THRESHOLD.
- data_valid_o  out  1  pix_o/edge_o valid this cycle.
- out_col_o  out  10  column index of the current output, 0..MAX_COL-3.
- out_row_o  out  10  row index of the current output, 0..MAX_ROW-3.
- row_done_o  out  1  one-cycle pulse with the last column's output of a row.
- frame_done_o  out  1  one-cycle pulse with the last output of the frame.

Behaviour:
- Reset: all outputs and internal registers go to 0 immediately (asynchronous) and stay 0 until the first post-reset edge.
- Reset mid-frame drops in-flight results: no data_valid_o for any window sampled before reset.
- Stage 1, registered on the edge with core_en_i=1:
  - gx_p = d02 + 2*d12 + d22; gx_n = d00 + 2*d10 + d20.
  - gy_p = d20 + 2*d21 + d22; gy_n = d00 + 2*d01 + d02.
  - Each sum is 10-bit unsigned, max 1020.
  - v1 = core_en_i.
- Stage 2:
  - ax = |gx_p - gx_n|, ay = |gy_p - gy_n|, using an 11-bit signed subtract; results 10-bit unsigned, max 1020.
  - v2 = v1.
- Stage 3:
  - s = ax + ay, 11-bit, max 2040.
  - pix_o = (s > 255) ? 255 : s[7:0].
  - edge_o = pix_o >= THRESHOLD.
  - data_valid_o = v2.
- Latency: window sampled at edge t appears on pix_o with data_valid_o=1 after edge t+2, i.e. the 3rd register stage.
- Throughput: 1/cycle. Gaps in core_en_i propagate as data_valid_o=0 bubbles. Outputs hold their last value when not valid; data_valid_o is the only qualifier.
- Position counters:
  - Advance only when data_valid_o is asserted.
  - out_col_o/out_row_o describe the result currently on pix_o.
  - After a valid output at col == MAX_COL-3: col wraps to 0 and row increments.
  - After a valid output at (MAX_COL-3, MAX_ROW-3): both wrap to 0.
- Done pulses:
  - row_done_o = data_valid_o && out_col_o == MAX_COL-3.
  - frame_done_o = row_done_o && out_row_o == MAX_ROW-3.
  - Both are combinational from registered state and are exactly one cycle wide.
- clear_i:
  - Takes priority over core_en_i on the same edge.
  - Zeros v1/v2/data_valid_o and the counters on the next edge; windows sampled on that edge are discarded.
  - pix_o and edge_o are also zeroed.
- Simultaneous frame end and new core_en_i: the pipeline continues; the next valid output is (col 0, row 0).

Test Plan:
- Reset, then one uniform window (all pixels 100), core_en_i one cycle -> after 3 edges data_valid_o=1 for 1 cycle, pix_o=0, edge_o=0, out_col_o=0.
- Window left column 0, right column 10, middle 5 -> Gx=40, Gy=0, pix_o=40, edge_o=0. Left 0, right 255 -> s=1020, pix_o=255, edge_o=1.
- Top row 200, middle 0, bottom 0 -> gy_n=800, Gy=-800, ay=800, pix_o=255. Top 0, bottom 30, middle 0 -> pix_o=120, edge_o=0.
- Streaming with MAX_COL=6, MAX_ROW=5, core_en_i high 12 consecutive cycles -> 12 valid outputs; row_done_o on outputs 4, 8, 12; frame_done_o only on output 12; counters read (0,0) afterwards.
- Same stream with core_en_i toggling 1/0 -> bubbles preserved, counters advance only on valid cycles, same done positions.
- Assert rst (and, separately, clear_i) while 2 windows are in flight -> no data_valid_o for them, counters 0; the next window produces a valid output at (col 0, row 0).
